sdm_interp_feeder: RTL and testbench
====================================

// Module: sdm_interp_feeder
// PURPOSE
//  Upstream stage of the SDM DAC path. Accepts PCM audio at the audio rate over a valid/ready stream.
//  Buffers it in a small FIFO and linearly interpolates by OSR.
//  Emits one 16-bit sample per modulator tick as a valid-strobed stream (drives valid_in_dac/audio_in).
// PARAMETERS
//  OSR         64  oversampling ratio; power of 2, 2..256; L = $clog2(OSR)
//  CLK_DIV     1   clk cycles per output strobe; >=1
//  FIFO_DEPTH  4   input FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  run        in   1   1 = generate output strobes; 0 = idle and flush
//  s_valid    in   1   input sample valid
//  s_ready    out  1   FIFO not full; transfer when s_valid && s_ready
//  s_data     in   16  signed PCM input sample
//  valid_out  out  1   1-cycle strobe, one per modulator tick
//  dout       out  16  signed interpolated sample, valid when valid_out=1
//  underrun   out  1   1-cycle pulse: FIFO empty at a segment boundary
//  fifo_level out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset values:
//   - valid_out=0, dout=0, underrun=0, fifo_level=0, s_ready=1.
//   - FIFO empty; cur=0, acc=0, delta=0, div/phase counters=0; state=IDLE.
//  FIFO:
//   - push when s_valid&&s_ready; s_ready = !full, registered occupancy, no combinational path from s_valid.
//   - Pop is internal only; no bypass, so a push and a pop in the same cycle on an empty FIFO means the pop sees empty.
//   - Push and pop in the same cycle when neither full nor empty: level unchanged.
//  FSM:
//   - IDLE->RUN when run=1 && fifo_level>=1.
//   - RUN->IDLE when run=0; takes effect next cycle.
//   - On entry to IDLE: no strobes, FIFO flushed, cur/acc/delta/counters cleared to 0.
//  Timing in RUN:
//   - div counter counts 0..CLK_DIV-1; tick = (div==CLK_DIV-1); with CLK_DIV=1, tick fires every cycle.
//   - Phase k counts 0..OSR-1 on each tick and wraps.
//   - Segment boundary = first tick after entering RUN, or a tick with k==OSR-1.
//  Segment load, in the cycle of the boundary tick:
//   - FIFO non-empty: pop n; delta<=n-cur (17b signed); acc<={cur,L'b0}; cur<=n.
//   - FIFO empty: delta<=0; acc<={cur,L'b0}; underrun pulses 1 cycle.
//  Output:
//   - On each tick, dout<=acc>>>L (arithmetic shift, floor) and valid_out<=1 one cycle later; then acc<=acc+delta.
//   - With the load, the first output of a segment is the old cur; the ramp reaches n at the next segment's k=0.
//   - acc width is 16+L+1 signed. Values are convex combinations of the 16-bit endpoints, so no saturation is needed and overflow cannot occur.
//  Latency:
//   - First valid_out comes CLK_DIV cycles after the IDLE->RUN transition.
//   - Strobe spacing is exactly CLK_DIV cycles while in RUN.
//  Reset mid-operation: asynchronously returns everything to the reset values; an in-flight strobe is dropped.
// STRUCTURE
//  Package sdm_pkg:
//   - typedef logic signed [15:0] pcm_t;
//   - typedef enum logic {IDLE,RUN} feeder_state_t;
//   - localparam PCM_W=16.
//  Sub-module sdm_sync_fifo (#WIDTH, #DEPTH): push/pop, full/empty, level. Reusable by the ADC side.
//  Top of this block: FSM, div/phase counters, interpolation accumulator.
// TESTING  (OSR=4, CLK_DIV=2, FIFO_DEPTH=4 unless noted)
//  1. Reset, run=0 -> valid_out=0, dout=0, underrun=0, s_ready=1, fifo_level=0; no strobes.
//  2. Push 400, then 800; run=1 -> dout 0,100,200,300,400,500,600,700, strobes every 2 clks; no underrun.
//  3. Segment 400 -> -400 -> dout 400,200,0,-200, then -400 at next boundary.
//  4. Segment 32767 -> -32768, OSR=256 -> monotone ramp; no wrap; first=32767; final=-32768 at next boundary.
//  5. After step 2, push nothing -> at boundary underrun pulses once; dout holds 800 for 4 strobes.
//  6. run=0: push 5 samples -> first 4 accepted, s_ready=0 on 5th, fifo_level=4.
//     Then run=1 -> pops resume; s_ready returns to 1.
//     Deassert run mid-segment -> valid_out=0 next cycle, fifo_level=0.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared types for the SDM DAC/ADC datapath blocks.
package sdm_pkg;

    localparam int PCM_W = 16;

    typedef logic signed [PCM_W-1:0] pcm_t;

    typedef enum logic {IDLE, RUN} feeder_state_t;

endpackage

// File: rtl/sdm_sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop are ignored when full/empty.
module sdm_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sdm_interp_feeder.sv
// Buffers audio-rate PCM and linearly interpolates it by OSR, one sample per modulator tick.
//  state | meaning
//  IDLE  | no strobes; FIFO, ramp and counters held cleared until run && data
//  RUN   | tick every CLK_DIV cycles, new segment loaded every OSR ticks
module sdm_interp_feeder
    import sdm_pkg::*;
#(
    parameter int OSR        = 64,
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [PCM_W-1:0]              s_data,
    output logic                          valid_out,
    output logic [PCM_W-1:0]              dout,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int L     = $clog2(OSR);
    localparam int ACC_W = PCM_W + L + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    feeder_state_t           state;
    logic [DIV_W-1:0]        div_cnt;
    logic [L-1:0]            phase;
    logic                    first_tick;
    pcm_t                    cur;
    logic signed [PCM_W:0]   delta;
    logic signed [ACC_W-1:0] acc;

    logic                    tick;
    logic                    boundary;
    logic                    flush;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [PCM_W-1:0]        fifo_dout;
    pcm_t                    seg_end;
    logic [PCM_W:0]          seg_delta;
    logic [ACC_W-1:0]        seg_base;

    sdm_sync_fifo #(
        .WIDTH (PCM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (s_valid),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign s_ready  = !fifo_full;
    assign flush    = (state == RUN) && !run;
    assign tick     = (state == RUN) && run && (div_cnt == DIV_W'(CLK_DIV - 1));
    // The first tick after entering RUN does not advance the phase, so every
    // segment, including the first, spans exactly OSR ticks.
    assign boundary = tick && (first_tick || (phase == L'(OSR - 1)));
    assign pop      = boundary && !fifo_empty;

    // An empty FIFO at a boundary repeats cur, giving a flat segment.
    always_comb begin
        seg_end   = fifo_empty ? cur : pcm_t'(fifo_dout);
        seg_delta = {seg_end[PCM_W-1], seg_end} - {cur[PCM_W-1], cur};
        seg_base  = {cur[PCM_W-1], cur, {L{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            phase      <= '0;
            first_tick <= 1'b0;
            cur        <= '0;
            delta      <= '0;
            acc        <= '0;
            valid_out  <= 1'b0;
            dout       <= '0;
            underrun   <= 1'b0;
        end else begin
            valid_out <= tick;
            underrun  <= boundary && fifo_empty;
            case (state)
                IDLE: begin
                    if (run && (fifo_level != '0)) begin
                        state      <= RUN;
                        div_cnt    <= '0;
                        phase      <= '0;
                        first_tick <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state      <= IDLE;
                        div_cnt    <= '0;
                        phase      <= '0;
                        first_tick <= 1'b0;
                        cur        <= '0;
                        delta      <= '0;
                        acc        <= '0;
                    end else begin
                        div_cnt <= tick ? '0 : div_cnt + 1'b1;
                        if (tick) begin
                            first_tick <= 1'b0;
                            if (!first_tick) phase <= phase + 1'b1;
                            if (boundary) begin
                                dout  <= cur;
                                cur   <= seg_end;
                                delta <= seg_delta;
                                acc   <= seg_base + {{L{seg_delta[PCM_W]}}, seg_delta};
                            end else begin
                                dout <= acc[L +: PCM_W];
                                acc  <= acc + {{L{delta[PCM_W]}}, delta};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdm_interp_feeder.sv
// Directed and random checks of sdm_interp_feeder against a segment-level interpolation model.
module tb_sdm_interp_feeder;

    localparam int OSR_A = 4;
    localparam int DIV_A = 2;
    localparam int DEP_A = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic               a_run = 1'b0;
    logic               a_s_valid = 1'b0;
    logic               a_s_ready;
    logic signed [15:0] a_s_data = '0;
    logic               a_valid;
    logic signed [15:0] a_dout;
    logic               a_under;
    logic [2:0]         a_level;

    logic               b_run = 1'b0;
    logic               b_s_valid = 1'b0;
    logic               b_s_ready;
    logic signed [15:0] b_s_data = '0;
    logic               b_valid;
    logic signed [15:0] b_dout;
    logic               b_under;
    logic [2:0]         b_level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pushed samples awaiting use, and the active segment a -> b.
    int mq[$];
    bit m_run = 0;
    int m_cyc = 0;
    int m_n   = 0;
    int m_cur = 0;
    int m_a   = 0;
    int m_b   = 0;
    int under_seen = 0;

    always #5 clk = ~clk;

    sdm_interp_feeder #(.OSR(OSR_A), .CLK_DIV(DIV_A), .FIFO_DEPTH(DEP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(a_run), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_data(a_s_data), .valid_out(a_valid), .dout(a_dout), .underrun(a_under),
        .fifo_level(a_level)
    );

    sdm_interp_feeder #(.OSR(256), .CLK_DIV(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(b_run), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .valid_out(b_valid), .dout(b_dout), .underrun(b_under),
        .fifo_level(b_level)
    );

    function automatic int floor_div(int num, int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0;
        m_cyc = 0;
        m_n   = 0;
        m_cur = 0;
        m_a   = 0;
        m_b   = 0;
    endtask

    // Advance one clock on DUT A and compare every observable output with the model.
    task automatic step_a();
        bit run_c, push_ok, exp_v, exp_u;
        int data_c, exp_d, j;
        run_c   = a_run;
        data_c  = a_s_data;
        push_ok = a_s_valid && (mq.size() < DEP_A);
        exp_v   = 0;
        exp_u   = 0;
        exp_d   = 0;
        @(posedge clk);
        #1;
        if (!m_run) begin
            if (run_c && mq.size() >= 1) begin
                m_run = 1;
                m_cyc = 0;
                m_n   = 0;
            end
            if (push_ok) mq.push_back(data_c);
        end else if (!run_c) begin
            mq.delete();
            m_run = 0;
            m_cur = 0;
        end else begin
            m_cyc++;
            if (m_cyc % DIV_A == 0) begin
                exp_v = 1;
                j = m_n % OSR_A;
                if (j == 0) begin
                    exp_d = m_cur;
                    m_a   = m_cur;
                    if (mq.size() > 0) m_b = mq.pop_front();
                    else begin
                        m_b   = m_cur;
                        exp_u = 1;
                    end
                    m_cur = m_b;
                end else begin
                    exp_d = m_a + floor_div(j * (m_b - m_a), OSR_A);
                end
                m_n++;
            end
            if (push_ok) mq.push_back(data_c);
        end
        if (a_under === 1'b1) under_seen++;
        chk("valid_out", a_valid, exp_v);
        chk("underrun", a_under, exp_u);
        if (exp_v) chk("dout", a_dout, exp_d);
        chk("fifo_level", a_level, mq.size());
        chk("s_ready", a_s_ready, (mq.size() < DEP_A) ? 1 : 0);
    endtask

    task automatic push_a(input int v);
        a_s_valid = 1'b1;
        a_s_data  = 16'(v);
        step_a();
        a_s_valid = 1'b0;
    endtask

    initial begin
        int j, guard, exp_b;

        // 1: reset state, no strobes while idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", a_valid, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_underrun", a_under, 0);
        chk("rst_s_ready", a_s_ready, 1);
        chk("rst_level", a_level, 0);
        rst_n = 1'b1;
        model_reset();
        repeat (4) step_a();

        // 2 and 5: ramp 0 -> 400 -> 800, then one underrun and a flat 800 segment
        push_a(400);
        push_a(800);
        a_run = 1'b1;
        under_seen = 0;
        repeat (25) step_a();
        chk("t5_underrun_count", under_seen, 1);
        a_run = 1'b0;
        step_a();

        // 3: 400 -> -400 falling segment
        push_a(400);
        push_a(-400);
        a_run = 1'b1;
        repeat (19) step_a();
        a_run = 1'b0;
        step_a();

        // 6: fill while idle, overflow attempt, resume, then stop mid-segment
        for (int i = 0; i < 5; i++) push_a(10 * (i + 1));
        chk("t6_level_full", a_level, 4);
        chk("t6_not_ready", a_s_ready, 0);
        a_run = 1'b1;
        repeat (12) step_a();
        a_run = 1'b0;
        step_a();
        chk("t6_flush_level", a_level, 0);
        chk("t6_flush_valid", a_valid, 0);

        // Random traffic with occasional run drops
        for (int c = 0; c < 400; c++) begin
            a_run     = ($urandom_range(0, 39) != 0);
            a_s_valid = ($urandom_range(0, 6) == 0);
            a_s_data  = 16'($urandom);
            step_a();
        end
        a_s_valid = 1'b0;

        // Asynchronous reset in the middle of a run
        push_a(1000);
        a_run = 1'b1;
        repeat (5) step_a();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", a_valid, 0);
        chk("midrst_dout", a_dout, 0);
        chk("midrst_level", a_level, 0);
        chk("midrst_s_ready", a_s_ready, 1);
        a_run = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) step_a();

        // 4: full-scale swing at OSR=256 on the second instance
        b_s_valid = 1'b1;
        b_s_data  = 16'sd32767;
        @(posedge clk);
        #1;
        b_s_data  = -16'sd32768;
        @(posedge clk);
        #1;
        b_s_valid = 1'b0;
        chk("b_level", b_level, 2);
        b_run = 1'b1;
        j = 0;
        guard = 0;
        while (j < 513 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
            if (b_valid === 1'b1) begin
                if (j < 256)      exp_b = floor_div(j * 32767, 256);
                else if (j < 512) exp_b = 32767 + floor_div((j - 256) * (-65535), 256);
                else              exp_b = -32768;
                chk("b_dout", b_dout, exp_b);
                chk("b_underrun", b_under, (j == 512) ? 1 : 0);
                j++;
            end
        end
        chk("b_strobe_count", j, 513);
        b_run = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
